// File: rtl/mem_stage_if.sv
// Byte-wide request/acknowledge port between the memory stage and the memory controller.
// master = memory stage (issues byte requests), slave = memory controller (acks bytes).
// One byte moves per cycle in which mem_req_o and mem_ack_i are both high.
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: passes ALU/JAL results through and serialises loads/stores into byte transfers.
// Latency: non-memory ops 0 cycles; n-byte access = 1 detect + n access (+ waits) + 1 done cycle.
// Backpressure: stall_req_o holds upstream until the last byte is acked; the controller may wait freely.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_e_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [4:0]        mem_length_i,
  mem_stage_if.master       mem,
  output logic              stall_req_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_e_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [DATA_W-1:0] buf_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdat_q;
  logic [1:0]        last_q;
  logic              store_q;
  logic              zext_q;

  logic [2:0]        bytes;
  logic [1:0]        last_idx;
  logic              start;
  logic              last_ack;
  logic              sign_b;
  logic              sign_h;
  logic [DATA_W-1:0] load_ext;

  assign bytes    = mem_length_i[2:0];
  assign start    = (state_q == IDLE) && (bytes != 3'd0);
  // Index of the final byte: 1 byte -> 0, 2 bytes -> 1, 4 bytes -> 3.
  assign last_idx = bytes[2] ? 2'd3 : (bytes[1] ? 2'd1 : 2'd0);
  assign last_ack = (state_q == ACCESS) && mem.mem_ack_i && (cnt_q == last_q);

  // Sign/zero extension of the assembled load word, chosen by access size.
  assign sign_b = buf_q[7]  & ~zext_q;
  assign sign_h = buf_q[15] & ~zext_q;
  always_comb begin
    load_ext = buf_q;
    case (last_q)
      2'd0:    load_ext = {{(DATA_W-8){sign_b}},  buf_q[7:0]};
      2'd1:    load_ext = {{(DATA_W-16){sign_h}}, buf_q[15:0]};
      default: load_ext = buf_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Access context: latched on detect, byte counter and load buffer advance on each ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      buf_q   <= '0;
      base_q  <= '0;
      wdat_q  <= '0;
      last_q  <= 2'd0;
      store_q <= 1'b0;
      zext_q  <= 1'b0;
    end else if (start) begin
      cnt_q   <= 2'd0;
      buf_q   <= '0;
      base_q  <= mem_length_i[3] ? mem_addr_i : rd_data_i[ADDR_W-1:0];
      wdat_q  <= rd_data_i;
      last_q  <= last_idx;
      store_q <= mem_length_i[3];
      zext_q  <= mem_length_i[4];
    end else if ((state_q == ACCESS) && mem.mem_ack_i) begin
      if (!store_q) buf_q[{cnt_q, 3'b000} +: 8] <= mem.mem_rdata_i;
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Next state and all outputs; reset forces every output low immediately.
  always_comb begin
    state_d         = state_q;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = 8'h00;
    stall_req_o     = 1'b0;
    rd_data_o       = '0;
    rd_addr_o       = 5'd0;
    rd_e_o          = 1'b0;
    case (state_q)
      IDLE: begin
        rd_addr_o = rd_addr_i;
        if (bytes == 3'd0) begin
          rd_data_o = rd_data_i;
          rd_e_o    = rd_e_i;
        end else begin
          stall_req_o = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        mem.mem_req_o  = 1'b1;
        mem.mem_we_o   = store_q;
        mem.mem_addr_o = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
        if (store_q) mem.mem_wdata_o = wdat_q[{cnt_q, 3'b000} +: 8];
        stall_req_o = 1'b1;
        rd_addr_o   = rd_addr_i;
        if (last_ack) state_d = DONE;
      end
      DONE: begin
        rd_addr_o = rd_addr_i;
        if (!store_q) begin
          rd_e_o    = rd_e_i;
          rd_data_o = load_ext;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem.mem_req_o   = 1'b0;
      mem.mem_we_o    = 1'b0;
      mem.mem_addr_o  = '0;
      mem.mem_wdata_o = 8'h00;
      stall_req_o     = 1'b0;
      rd_data_o       = '0;
      rd_addr_o       = 5'd0;
      rd_e_o          = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-transfer scoreboard and a memory responder.
// Expected byte transfers are queued when an instruction is driven and popped as the DUT requests them.
// Expected write-back values are computed from the applied stimulus.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rd_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_e_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [4:0]  mem_length_i = '0;
  logic        stall_req_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_e_o;

  mem_stage_if #(.ADDR_W(32)) bus ();

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_e_i(rd_e_i),
    .mem_addr_i(mem_addr_i), .mem_length_i(mem_length_i),
    .mem(bus),
    .stall_req_o(stall_req_o), .rd_data_o(rd_data_o),
    .rd_addr_o(rd_addr_o), .rd_e_o(rd_e_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } xfer_t;

  xfer_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one memory instruction and act as the controller until its DONE cycle.
  task automatic run_op(input string tag, input logic [31:0] data, input logic [31:0] maddr,
                        input logic [4:0] len, input int waits, input logic [31:0] rbytes,
                        input logic [31:0] exp_wb);
    int n;
    logic st;
    logic [31:0] base;
    int stall_cycles;
    int wl;
    int idx;
    bit done;
    xfer_t x;
    n    = int'(len[2:0]);
    st   = len[3];
    base = st ? maddr : data;
    for (int i = 0; i < n; i++) begin
      x.addr  = base + 32'(i);
      x.we    = st;
      x.wdata = st ? data[8*i +: 8] : 8'h00;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    rd_data_i = data; rd_addr_i = 5'd7; rd_e_i = 1'b1;
    mem_addr_i = maddr; mem_length_i = len; bus.mem_ack_i = 1'b0;
    #1;
    chk({tag, " detect stall"}, 32'(stall_req_o), 32'd1);
    chk({tag, " detect rd_e"}, 32'(rd_e_o), 32'd0);
    chk({tag, " detect req"}, 32'(bus.mem_req_o), 32'd0);
    stall_cycles = 1; wl = waits; idx = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      #1;
      if (bus.mem_req_o) begin
        stall_cycles++;
        chk({tag, " access stall"}, 32'(stall_req_o), 32'd1);
        chk({tag, " access rd_e"}, 32'(rd_e_o), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s extra byte request: addr=%h", tag, bus.mem_addr_o);
        end else begin
          chk({tag, " addr"}, bus.mem_addr_o, exp_q[0].addr);
          chk({tag, " we"}, 32'(bus.mem_we_o), 32'(exp_q[0].we));
          if (st) chk({tag, " wdata"}, 32'(bus.mem_wdata_o), 32'(exp_q[0].wdata));
          if (wl > 0) begin
            wl--;
          end else begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = rbytes[8*idx +: 8];
            idx++;
            void'(exp_q.pop_front());
            wl = waits;
          end
        end
      end else begin
        done = 1;
        chk({tag, " done stall"}, 32'(stall_req_o), 32'd0);
        chk({tag, " done rd_e"}, 32'(rd_e_o), st ? 32'd0 : 32'd1);
        if (!st) begin
          chk({tag, " wb data"}, rd_data_o, exp_wb);
          chk({tag, " wb addr"}, 32'(rd_addr_o), 32'd7);
        end
        chk({tag, " bytes left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, " stall cycles"}, 32'(stall_cycles), 32'(n + 1 + n * waits));
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: no DONE within 200 cycles", tag);
      exp_q.delete();
    end
  endtask

  initial begin
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = 8'h00;
    rd_data_i = 32'h55; rd_e_i = 1'b1; rd_addr_i = 5'd3;
    #12;
    chk("reset rd_data", rd_data_o, 32'd0);
    chk("reset rd_e", 32'(rd_e_o), 32'd0);
    chk("reset stall", 32'(stall_req_o), 32'd0);
    chk("reset req", 32'(bus.mem_req_o), 32'd0);
    @(negedge clk); rst = 1'b0;

    // ALU pass-through, combinational
    @(posedge clk); #1;
    rd_data_i = 32'h1234; rd_addr_i = 5'd5; rd_e_i = 1'b1; mem_addr_i = 0; mem_length_i = 5'h00;
    #1;
    chk("pass rd_data", rd_data_o, 32'h1234);
    chk("pass rd_addr", 32'(rd_addr_o), 32'd5);
    chk("pass rd_e", 32'(rd_e_o), 32'd1);
    chk("pass stall", 32'(stall_req_o), 32'd0);
    chk("pass req", 32'(bus.mem_req_o), 32'd0);

    run_op("LW",  32'h0000_0100, 32'h0, 5'h04, 0, 32'h1234_5678, 32'h1234_5678);
    run_op("LB",  32'h0000_0020, 32'h0, 5'h01, 0, 32'h0000_0080, 32'hFFFF_FF80);
    run_op("LBU", 32'h0000_0020, 32'h0, 5'h11, 0, 32'h0000_0080, 32'h0000_0080);
    run_op("SH",  32'hAABB_CCDD, 32'h3, 5'h0A, 2, 32'h0,         32'h0);
    run_op("LHW", 32'hFFFF_FFFF, 32'h0, 5'h02, 0, 32'h0000_8001, 32'hFFFF_8001);
    run_op("LHU", 32'h0000_0041, 32'h0, 5'h12, 1, 32'h0000_9A7F, 32'h0000_9A7F);
    run_op("SW",  32'hDEAD_BEEF, 32'h7, 5'h0C, 0, 32'h0,         32'h0);

    // Reset in the middle of a word load after two acked bytes
    @(posedge clk); #1;
    rd_data_i = 32'h200; rd_addr_i = 5'd9; rd_e_i = 1'b1; mem_addr_i = 0; mem_length_i = 5'h04;
    bus.mem_ack_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      #1;
      chk("rst-lw addr", bus.mem_addr_o, 32'h200 + 32'(b));
      bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 8'hA5;
    end
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    #1;
    chk("rst-lw third req", 32'(bus.mem_req_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst-lw req", 32'(bus.mem_req_o), 32'd0);
    chk("rst-lw stall", 32'(stall_req_o), 32'd0);
    chk("rst-lw addr out", bus.mem_addr_o, 32'd0);
    chk("rst-lw rd_data", rd_data_o, 32'd0);
    chk("rst-lw rd_e", 32'(rd_e_o), 32'd0);
    chk("rst-lw rd_addr", 32'(rd_addr_o), 32'd0);
    mem_length_i = 5'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("LB after rst", 32'h0000_0300, 32'h0, 5'h01, 0, 32'h0000_007E, 32'h0000_007E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
